// File: rtl/debounce_edge_counter.sv
// debounce_edge_counter: 2-FF synchronizer -> stability-timer debouncer ->
// rising-edge detector -> up/down edge counter.
// Define DEBCNT_SATURATE_EN to make the counter saturate ("up" holds at all-ones,
// "down" holds at zero) instead of wrapping modulo 2^WIDTH.
module debounce_edge_counter #(
  parameter int    MODULUS = 2_500_000,
  parameter int    WIDTH   = 10,
  parameter string UP_DOWN = "up"
) (
  input  logic             i_clk,
  input  logic             i_sclr,
  input  logic             i_in,
  output logic             o_out,
  output logic             o_en,
  output logic [WIDTH-1:0] o_cnt
);

  localparam int          TW   = $clog2(MODULUS);
  localparam logic [TW-1:0] TMAX = TW'(MODULUS - 1);
  localparam bit          DOWN = (UP_DOWN == "down");

  logic [1:0]       sync_q;
  logic             sync2;
  logic [TW-1:0]    timer;
  logic             o_prev;
  logic [WIDTH-1:0] cnt_nxt;

  assign sync2 = sync_q[1];

  // two-flop synchronizer; the switch is asynchronous to i_clk
  always_ff @(posedge i_clk) begin
    if (!i_sclr) sync_q <= '0;
    else         sync_q <= {sync_q[0], i_in};
  end

  // stability timer: o_out follows only after MODULUS consecutive differing cycles
  always_ff @(posedge i_clk) begin
    if (!i_sclr) begin
      timer <= '0;
      o_out <= 1'b0;
    end else if (sync2 == o_out) begin
      timer <= '0;
    end else if (timer == TMAX) begin
      o_out <= sync2;
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // edge history; o_en marks the first cycle o_out is high
  always_ff @(posedge i_clk) begin
    if (!i_sclr) o_prev <= 1'b0;
    else         o_prev <= o_out;
  end

  assign o_en = o_out & ~o_prev;

  // next count: step per edge, wrapping or saturating depending on build
  always_comb begin
    cnt_nxt = o_cnt;
    if (DOWN) begin
`ifdef DEBCNT_SATURATE_EN
      if (o_cnt != '0) cnt_nxt = o_cnt - WIDTH'(1);
`else
      cnt_nxt = o_cnt - WIDTH'(1);
`endif
    end else begin
`ifdef DEBCNT_SATURATE_EN
      if (o_cnt != '1) cnt_nxt = o_cnt + WIDTH'(1);
`else
      cnt_nxt = o_cnt + WIDTH'(1);
`endif
    end
  end

  // edge counter; reset wins over a coincident o_en
  always_ff @(posedge i_clk) begin
    if (!i_sclr)   o_cnt <= '0;
    else if (o_en) o_cnt <= cnt_nxt;
  end

endmodule

// File: tb/tb_debounce_edge_counter.sv
// Bench for debounce_edge_counter: vector table, bounce/press sequences,
// and random stimulus compared every cycle against a run-length reference model.
`timescale 1ns/100ps
module tb_debounce_edge_counter;

  localparam int M  = 500;
  localparam int W  = 10;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic sclr = 1'b0, din = 1'b0;
  logic sclr2 = 1'b0, din2 = 1'b0;
  logic out, en;
  logic [W-1:0] cnt;
  logic out_u, en_u, out_d, en_d;
  logic [1:0] cnt_u, cnt_d;

  int checks = 0, failures = 0, nprint = 0, en_seen = 0;
  bit chk_on = 1'b0;

  always #10 clk = ~clk;

  debounce_edge_counter #(.MODULUS(M), .WIDTH(W), .UP_DOWN("up")) dut (
    .i_clk(clk), .i_sclr(sclr), .i_in(din), .o_out(out), .o_en(en), .o_cnt(cnt));

  debounce_edge_counter #(.MODULUS(MS), .WIDTH(2), .UP_DOWN("up")) dut_u (
    .i_clk(clk), .i_sclr(sclr2), .i_in(din2), .o_out(out_u), .o_en(en_u), .o_cnt(cnt_u));

  debounce_edge_counter #(.MODULUS(MS), .WIDTH(2), .UP_DOWN("down")) dut_d (
    .i_clk(clk), .i_sclr(sclr2), .i_in(din2), .o_out(out_d), .o_en(en_d), .o_cnt(cnt_d));

  // reference model: the clean level flips once the value seen two samples late
  // has disagreed with it for M consecutive clock edges; each 0->1 flip of the
  // clean level is counted on the following edge
  logic [1:0]   m_hist;
  logic         m_out, m_prev;
  int           m_run;
  logic [W-1:0] m_cnt;

  function automatic logic [W-1:0] m_step(input logic [W-1:0] c);
`ifdef DEBCNT_SATURATE_EN
    return (c == {W{1'b1}}) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (!sclr) begin
      m_hist = 2'b00; m_out = 1'b0; m_prev = 1'b0; m_run = 0; m_cnt = '0;
    end else begin
      if (m_out && !m_prev) m_cnt = m_step(m_cnt);
      m_prev = m_out;
      if (m_hist[1] != m_out) begin
        m_run++;
        if (m_run == M) begin m_out = m_hist[1]; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_hist = {m_hist[0], din};
    end
  end

  always @(posedge clk) if (en) en_seen++;

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (out !== m_out || en !== (m_out & ~m_prev) || cnt !== m_cnt) begin
        failures++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL model_cmp t=%0t out=%b exp=%b en=%b exp=%b cnt=%0d exp=%0d",
                   $time, out, m_out, en, m_out & ~m_prev, cnt, m_cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit sclr;
    bit din;
    int n;
    bit out;
    bit en;
    int cnt;
  } vec_t;

  vec_t vec[20];

  task automatic bounce(input int npulse);
    #0.5;
    for (int i = 0; i < npulse; i++) begin
      din = 1'b1; #($urandom_range(1, 10));
      din = 1'b0; #($urandom_range(1, 10));
    end
    #100;
    @(negedge clk);
  endtask

  task automatic press2();
    din2 = 1'b1; repeat (12) @(negedge clk);
    din2 = 1'b0; repeat (12) @(negedge clk);
  endtask

  initial begin
    int n;
    int exp_u[4];
    int exp_d[4];
`ifdef DEBCNT_SATURATE_EN
    exp_u = '{1, 2, 3, 3};
    exp_d = '{0, 0, 0, 0};
`else
    exp_u = '{1, 2, 3, 0};
    exp_d = '{3, 2, 1, 0};
`endif
    // {sclr, din, edges, out, en, cnt}
    vec[0]  = '{0, 0,    2, 0, 0, 0};  // reset
    vec[1]  = '{1, 0,   10, 0, 0, 0};
    vec[2]  = '{1, 1,  501, 0, 0, 0};  // one edge short of qualification
    vec[3]  = '{1, 1,    1, 1, 1, 0};  // rises at edge 502, pulse
    vec[4]  = '{1, 1,    1, 1, 0, 1};  // count follows a cycle later
    vec[5]  = '{1, 1, 1000, 1, 0, 1};
    vec[6]  = '{1, 0,  501, 1, 0, 1};
    vec[7]  = '{1, 0,    1, 0, 0, 1};  // falling edge: no pulse
    vec[8]  = '{1, 0,  598, 0, 0, 1};
    vec[9]  = '{1, 1,  502, 1, 1, 1};
    vec[10] = '{1, 1,    1, 1, 0, 2};
    vec[11] = '{1, 1,   97, 1, 0, 2};
    vec[12] = '{1, 0,  499, 1, 0, 2};  // 499-cycle glitch
    vec[13] = '{1, 1,   10, 1, 0, 2};
    vec[14] = '{1, 0,  300, 1, 0, 2};  // timer mid-count
    vec[15] = '{0, 0,    1, 0, 0, 0};  // reset discards partial timing
    vec[16] = '{1, 0,    1, 0, 0, 0};
    vec[17] = '{1, 1,  501, 0, 0, 0};  // full fresh qualification needed
    vec[18] = '{1, 1,    1, 1, 1, 0};
    vec[19] = '{1, 1,    1, 1, 0, 1};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sclr = vec[i].sclr;
      din  = vec[i].din;
      repeat (vec[i].n) @(negedge clk);
      chk($sformatf("vec%0d_out", i), int'(out), int'(vec[i].out));
      chk($sformatf("vec%0d_en", i), int'(en), int'(vec[i].en));
      chk($sformatf("vec%0d_cnt", i), int'(cnt), vec[i].cnt);
      if (i == 0) chk_on = 1'b1;
    end

    // bounce bursts with the line settling low: nothing qualifies
    din = 1'b0; repeat (600) @(negedge clk);
    en_seen = 0;
    bounce(10);
    bounce(12);
    repeat (20) @(negedge clk);
    chk("bounce_out", int'(out), 0);
    chk("bounce_en_pulses", en_seen, 0);
    chk("bounce_cnt", int'(cnt), 1);
    // then a clean 30 us hold: exactly one pulse, one count
    din = 1'b1; repeat (1500) @(negedge clk);
    chk("hold_out", int'(out), 1);
    chk("hold_en_pulses", en_seen, 1);
    chk("hold_cnt", int'(cnt), 2);

    // random glitches, long holds and stray resets against the model
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        sclr = 1'b0; @(negedge clk); sclr = 1'b1;
      end
      din = ~din;
      n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 499)) : int'($urandom_range(500, 700));
      repeat (n) @(negedge clk);
    end
    chk_on = 1'b0;

    // 2-bit counters: wrap or saturate
    sclr2 = 1'b0; repeat (2) @(negedge clk);
    sclr2 = 1'b1;
    chk("w2_reset_up", int'(cnt_u), 0);
    chk("w2_reset_down", int'(cnt_d), 0);
    for (int k = 0; k < 4; k++) begin
      press2();
      chk($sformatf("w2_up_press%0d", k + 1), int'(cnt_u), exp_u[k]);
      chk($sformatf("w2_down_press%0d", k + 1), int'(cnt_d), exp_d[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
